// File: rtl/instr_encoder.sv
// Program loader: encodes MIPS-style instruction requests into 32-bit words
// and writes them to consecutive instruction-memory addresses from base_addr.
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  base_addr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        imem_we,
    output logic [9:0]  imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [10:0] instr_count
);

    localparam logic [3:0] OP_R       = 4'd0;
    localparam logic [3:0] OP_LW      = 4'd1;
    localparam logic [3:0] OP_SW      = 4'd2;
    localparam logic [3:0] OP_BEQ     = 4'd3;
    localparam logic [3:0] OP_BNE     = 4'd4;
    localparam logic [3:0] OP_J       = 4'd5;
    localparam logic [3:0] OP_JAL     = 4'd6;
    localparam logic [3:0] OP_ADDI    = 4'd7;
    localparam logic [3:0] OP_ANDI    = 4'd8;
    localparam logic [3:0] OP_ORI     = 4'd9;
    localparam logic [3:0] OP_XORI    = 4'd10;
    localparam logic [3:0] OP_SLTI    = 4'd11;
    localparam logic [3:0] OP_LB      = 4'd12;
    localparam logic [3:0] OP_LUI     = 4'd13;
    localparam logic [3:0] OP_SYSCALL = 4'd14;
    localparam logic [3:0] OP_HALT    = 4'd15;

    localparam logic [9:0]  ADDR_LAST = 10'd1023;
    localparam logic [10:0] CNT_MAX   = 11'd1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [9:0]  addr_cnt;
    logic [10:0] count;
    logic        done_r;
    logic        ovf_r;

    logic        xfer_p0;
    logic        halt_p0;
    logic        last_p0;
    logic [31:0] word_p0;

    logic        vld_p1;
    logic [9:0]  addr_p1;
    logic [31:0] wdata_p1;

    function automatic logic [5:0] opcode_of(input logic [3:0] op);
        logic [5:0] opc;
        case (op)
            OP_R:       opc = 6'd0;
            OP_LW:      opc = 6'd35;
            OP_SW:      opc = 6'd43;
            OP_BEQ:     opc = 6'd4;
            OP_BNE:     opc = 6'd5;
            OP_J:       opc = 6'd2;
            OP_JAL:     opc = 6'd3;
            OP_ADDI:    opc = 6'd8;
            OP_ANDI:    opc = 6'd12;
            OP_ORI:     opc = 6'd13;
            OP_XORI:    opc = 6'd14;
            OP_SLTI:    opc = 6'd10;
            OP_LB:      opc = 6'd32;
            OP_LUI:     opc = 6'd15;
            OP_SYSCALL: opc = 6'd62;
            default:    opc = 6'd63;
        endcase
        return opc;
    endfunction

    function automatic logic [31:0] encode(
        input logic [3:0]  op,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [4:0]  f_shamt,
        input logic [5:0]  f_funct,
        input logic [15:0] f_imm,
        input logic [25:0] f_target
    );
        logic [5:0]  opc;
        logic [31:0] word;
        opc = opcode_of(op);
        case (op)
            OP_R:                word = {6'd0, f_rs, f_rt, f_rd, f_shamt, f_funct};
            OP_J, OP_JAL:        word = {opc, f_target};
            OP_SYSCALL, OP_HALT: word = {opc, 26'd0};
            // lui has no source register; the rs field is forced to zero
            OP_LUI:              word = {opc, 5'd0, f_rt, f_imm};
            default:             word = {opc, f_rs, f_rt, f_imm};
        endcase
        return word;
    endfunction

    // ---- stage p0: handshake and encode ----
    // start wins over a simultaneous request, so ready is masked by it
    assign req_ready = (state == LOAD) && !start;
    assign busy      = (state == LOAD);
    assign xfer_p0   = req_valid && req_ready;
    assign halt_p0   = (op_sel == OP_HALT);
    assign last_p0   = (addr_cnt == ADDR_LAST);
    assign word_p0   = encode(op_sel, rs, rt, rd, shamt, funct, imm, target);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (start) begin
            next_state = LOAD;
        end else if (xfer_p0 && (halt_p0 || last_p0)) begin
            next_state = DONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_cnt <= '0;
            count    <= '0;
            done_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (start) begin
            addr_cnt <= base_addr;
            count    <= '0;
            done_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (xfer_p0) begin
            // the last address is held rather than wrapped; DONE blocks further writes
            if (!last_p0) begin
                addr_cnt <= addr_cnt + 10'd1;
            end
            if (count != CNT_MAX) begin
                count <= count + 11'd1;
            end
            if (halt_p0) begin
                done_r <= 1'b1;
            end else if (last_p0) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // ---- stage p1: registered memory write ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            addr_p1  <= '0;
            wdata_p1 <= '0;
        end else begin
            vld_p1 <= xfer_p0;
            if (xfer_p0) begin
                addr_p1  <= addr_cnt;
                wdata_p1 <= word_p0;
            end
        end
    end

    assign imem_we     = vld_p1;
    assign imem_addr   = addr_p1;
    assign imem_wdata  = wdata_p1;
    assign done        = done_r;
    assign overflow    = ovf_r;
    assign instr_count = count;

endmodule
